// File: rtl/count_stream_checker_pkg.sv
// count_check_pkg: shared state encoding, error-counter width, saturating increment and default targets.
package count_check_pkg;
    typedef enum logic [1:0] {IDLE, TRACK, DONE, FAIL} state_t;
    localparam int ERR_W = 16;
    localparam int unsigned DEF_HIT_A        = 50;
    localparam int unsigned DEF_HIT_B        = 500;
    localparam int unsigned DEF_END_COUNT    = 99;
    localparam int unsigned DEF_MAX_ERRORS   = 8;
    localparam int unsigned DEF_STALL_CYCLES = 16;
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction
endpackage

// File: rtl/count_stream_checker_stall_timer.sv
// count_stall_timer: counts consecutive stalled cycles and pulses o_expire on the STALL_CYCLES-th one.
// Ports: i_clk, i_reset (sync, active-high), i_enable (stalled cycle), i_clear (restart), o_expire (pulse).
module count_stall_timer #(
    parameter int unsigned STALL_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire
);
    localparam int CW = $clog2(STALL_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    // Expiry is seen on the cycle that would make the count reach STALL_CYCLES, so the counter restarts from zero.
    assign o_expire = i_enable && (r_cnt == CW'(STALL_CYCLES - 1));
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear || o_expire) r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/count_stream_checker.sv
// count_stream_checker: checks a valid-qualified count stream starts at 0 and increments by 1 mod 2^WIDTH.
// Ports: i_clk, i_reset (sync, active-high), i_in_valid/i_in_count (sample), o_expected (next expected),
//        o_hit_a/o_hit_b (target pulses), o_seen_a/o_seen_b (sticky), o_err_count, o_first_err, o_done, o_fail.
module count_stream_checker
    import count_check_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned HIT_A        = DEF_HIT_A,
    parameter int unsigned HIT_B        = DEF_HIT_B,
    parameter int unsigned END_COUNT    = DEF_END_COUNT,
    parameter int unsigned MAX_ERRORS   = DEF_MAX_ERRORS,
    parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_count,
    output logic [WIDTH-1:0] o_expected,
    output logic             o_hit_a,
    output logic             o_hit_b,
    output logic             o_seen_a,
    output logic             o_seen_b,
    output logic [ERR_W-1:0] o_err_count,
    output logic [WIDTH-1:0] o_first_err,
    output logic             o_done,
    output logic             o_fail
);
    localparam logic [WIDTH-1:0] L_HIT_A = WIDTH'(HIT_A);
    localparam logic [WIDTH-1:0] L_HIT_B = WIDTH'(HIT_B);
    localparam logic [WIDTH-1:0] L_END   = WIDTH'(END_COUNT);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_expected, r_first_err;
    logic [ERR_W-1:0] r_err, w_err_next;
    logic r_hit_a, r_hit_b, r_seen_a, r_seen_b, r_first_set;
    logic w_accept, w_mismatch, w_expire, w_inc, w_max, w_hit_a, w_hit_b;
    assign w_accept   = i_in_valid && (r_state == IDLE || r_state == TRACK);
    // In IDLE the reference is 0; in TRACK it is the running expectation.
    assign w_mismatch = w_accept && (i_in_count != (r_state == IDLE ? '0 : r_expected));
    assign w_inc      = w_mismatch || w_expire;
    assign w_err_next = w_inc ? sat_inc(r_err) : r_err;
    assign w_max      = w_inc && (32'(w_err_next) >= MAX_ERRORS);
    assign w_hit_a    = w_accept && (i_in_count == L_HIT_A);
    assign w_hit_b    = w_accept && (i_in_count == L_HIT_B);
    count_stall_timer #(.STALL_CYCLES(STALL_CYCLES)) u_stall (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (r_state == TRACK && !i_in_valid),
        .i_clear  (r_state != TRACK || i_in_valid),
        .o_expire (w_expire)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // Reaching MAX_ERRORS outranks completion; only IDLE/TRACK can accept or stall, so DONE/FAIL hold.
    always_comb begin
        w_next = w_max ? FAIL : w_accept ? (i_in_count == L_END ? DONE : TRACK) : r_state;
    end
    // Every accepted sample resyncs: on a match in_count+1 equals expected+1 anyway.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_expected  <= '0;
            r_first_err <= '0;
            r_first_set <= 1'b0;
            r_err       <= '0;
            r_hit_a     <= 1'b0;
            r_hit_b     <= 1'b0;
            r_seen_a    <= 1'b0;
            r_seen_b    <= 1'b0;
        end else begin
            if (w_accept) r_expected <= i_in_count + WIDTH'(1);
            if (w_mismatch && !r_first_set) begin
                r_first_err <= i_in_count;
                r_first_set <= 1'b1;
            end
            r_err    <= w_err_next;
            r_hit_a  <= w_hit_a;
            r_hit_b  <= w_hit_b;
            r_seen_a <= r_seen_a | w_hit_a;
            r_seen_b <= r_seen_b | w_hit_b;
        end
    end
    always_comb begin
        o_done      = r_state == DONE || r_state == FAIL;
        o_fail      = r_err != '0 || r_state == FAIL;
        o_expected  = r_expected;
        o_first_err = r_first_err;
        o_err_count = r_err;
        o_hit_a     = r_hit_a;
        o_hit_b     = r_hit_b;
        o_seen_a    = r_seen_a;
        o_seen_b    = r_seen_b;
    end
endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker: directed and randomized checks of count_stream_checker against a behavioural model.
module tb_count_stream_checker;
    logic clk = 1'b0, rst = 1'b0, v = 1'b0, v8 = 1'b0;
    logic [31:0] c = '0, o_expected, o_first_err;
    logic [7:0] c8 = '0, e8, f8;
    logic [15:0] o_err, err8;
    logic o_hit_a, o_hit_b, o_seen_a, o_seen_b, o_done, o_fail;
    logic h8a, h8b, s8a, s8b, d8, fl8;
    int vectors = 0, miscompares = 0, hits_a = 0;
    bit m_started, m_term, m_failed, m_have_first, m_hit_a, m_hit_b, m_seen_a, m_seen_b;
    bit [31:0] m_exp, m_first;
    int m_err, m_stall;

    always #5 clk = ~clk;

    count_stream_checker dut (
        .i_clk(clk), .i_reset(rst), .i_in_valid(v), .i_in_count(c),
        .o_expected(o_expected), .o_hit_a(o_hit_a), .o_hit_b(o_hit_b),
        .o_seen_a(o_seen_a), .o_seen_b(o_seen_b), .o_err_count(o_err),
        .o_first_err(o_first_err), .o_done(o_done), .o_fail(o_fail)
    );

    count_stream_checker #(.WIDTH(8), .HIT_A(255), .HIT_B(255), .END_COUNT(3)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(v8), .i_in_count(c8),
        .o_expected(e8), .o_hit_a(h8a), .o_hit_b(h8b),
        .o_seen_a(s8a), .o_seen_b(s8b), .o_err_count(err8),
        .o_first_err(f8), .o_done(d8), .o_fail(fl8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic m_reset();
        m_started = 0; m_term = 0; m_failed = 0; m_have_first = 0;
        m_hit_a = 0; m_hit_b = 0; m_seen_a = 0; m_seen_b = 0;
        m_exp = 0; m_first = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic m_error();
        if (m_err < 65535) m_err++;
        if (m_err >= 8) begin m_term = 1; m_failed = 1; end
    endtask

    task automatic m_step(input bit vv, input bit [31:0] cc);
        bit bad;
        m_hit_a = 0; m_hit_b = 0;
        if (m_term) return;
        if (vv) begin
            bad = cc != (m_started ? m_exp : 32'd0);
            m_hit_a = cc == 50; m_hit_b = cc == 500;
            m_seen_a |= m_hit_a; m_seen_b |= m_hit_b;
            m_exp = cc + 1; m_started = 1; m_stall = 0;
            if (bad) begin
                if (!m_have_first) begin m_first = cc; m_have_first = 1; end
                m_error();
            end
            if (!m_failed && cc == 99) m_term = 1;
        end else if (m_started) begin
            m_stall++;
            if (m_stall == 16) begin m_stall = 0; m_error(); end
        end
    endtask

    task automatic cyc(input bit vv, input bit [31:0] cc);
        v = vv; c = cc;
        @(posedge clk);
        if (rst) m_reset(); else m_step(vv, cc);
        #1;
        chk("expected", 64'(o_expected), 64'(m_exp));
        chk("flags", 64'({o_hit_a, o_hit_b, o_seen_a, o_seen_b, o_done, o_fail}),
            64'({m_hit_a, m_hit_b, m_seen_a, m_seen_b, m_term, m_failed || m_err != 0}));
        chk("err_count", 64'(o_err), 64'(m_err[15:0]));
        chk("first_err", 64'(o_first_err), 64'(m_first));
        if (o_hit_a) hits_a++;
    endtask

    task automatic do_reset();
        rst = 1; cyc(0, 0); rst = 0;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) cyc(1, i);
    endtask

    task automatic cyc8(input bit [7:0] cc, input bit [7:0] we, input bit [15:0] werr, input bit [7:0] wf,
                        input bit [5:0] wflags);
        v8 = 1; c8 = cc;
        @(posedge clk); #1;
        chk("w8_expected", 64'(e8), 64'(we));
        chk("w8_err", 64'(err8), 64'(werr));
        chk("w8_first", 64'(f8), 64'(wf));
        chk("w8_flags", 64'({h8a, h8b, s8a, s8b, d8, fl8}), 64'(wflags));
    endtask

    initial begin
        m_reset();
        do_reset();
        chk("reset_all", 64'({o_expected, o_done, o_fail, o_err}), 64'd0);
        hits_a = 0;
        run(0, 99);
        chk("t1_done", 64'({o_done, o_fail}), 64'b10);
        chk("t1_err", 64'(o_err), 64'd0);
        chk("t1_exp", 64'(o_expected), 64'd100);
        chk("t1_seen", 64'({o_seen_a, o_seen_b}), 64'b10);
        chk("t1_hit_a_once", 64'(hits_a), 64'd1);
        cyc(1, 100); cyc(1, 7);
        chk("t1_frozen", 64'({o_expected, o_err}), 64'({32'd100, 16'd0}));

        do_reset();
        run(0, 20); run(22, 99);
        chk("t2_err", 64'(o_err), 64'd1);
        chk("t2_first", 64'(o_first_err), 64'd22);
        chk("t2_done_fail", 64'({o_done, o_fail}), 64'b11);

        do_reset();
        cyc(1, 5);
        chk("t3_exp6", 64'(o_expected), 64'd6);
        cyc(1, 6);
        chk("t3_exp7", 64'(o_expected), 64'd7);
        run(7, 99);
        chk("t3_err_first", 64'({o_err, o_first_err}), 64'({16'd1, 32'd5}));
        chk("t3_done_fail", 64'({o_done, o_fail}), 64'b11);

        do_reset();
        run(0, 10);
        for (int i = 0; i < 40; i++) cyc(0, 0);
        chk("t4_stall_err", 64'(o_err), 64'd2);
        run(11, 99);
        chk("t4_err_end", 64'({o_err, o_first_err}), 64'({16'd2, 32'd0}));

        do_reset();
        cyc(1, 0);
        for (int k = 0; k < 8; k++) cyc(1, 1000 + 10 * k);
        chk("t5_fail", 64'({o_done, o_fail, o_err}), 64'({2'b11, 16'd8}));
        cyc(1, 1071); cyc(1, 99); cyc(0, 0);
        chk("t5_ignored", 64'({o_expected, o_err}), 64'({32'd1071, 16'd8}));

        do_reset();
        run(0, 30);
        rst = 1; cyc(1, 31); rst = 0;
        chk("t6_midreset", 64'({o_expected, o_err, o_seen_a, o_done, o_fail}), 64'd0);

        cyc8(254, 255, 1, 254, 6'b000001);
        cyc8(255, 0, 1, 254, 6'b111101);
        cyc8(0, 1, 1, 254, 6'b001101);
        cyc8(1, 2, 1, 254, 6'b001101);
        cyc8(2, 3, 1, 254, 6'b001101);
        cyc8(3, 4, 1, 254, 6'b001111);
        v8 = 0;

        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                int sel;
                sel = $urandom_range(0, 31);
                if ($urandom_range(0, 149) == 0) begin rst = 1; cyc(0, 0); rst = 0; end
                else if (sel < 6) cyc(0, 0);
                else if (sel == 6) for (int j = 0; j < 18; j++) cyc(0, 0);
                else if (sel == 7) cyc(1, $urandom_range(0, 120));
                else if (sel == 8) cyc(1, $urandom_range(490, 510));
                else cyc(1, m_exp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Consumer/checker end of the free-running count stream produced by the simulation counters.
- Accepts a valid-qualified count sample each cycle and checks that the sequence starts at 0 and increments by 1 modulo 2^WIDTH.
- Flags hits at two target values, counts errors and stalls, and raises done/fail for the testbench's end-of-sim decision.
- Sits beside the counter in the sim top and is driven from the same clk.

Parameters:
- WIDTH, 32, count sample width.
- HIT_A, 50, first target value (pulse + sticky flag).
- HIT_B, 500, second target value (pulse + sticky flag).
- END_COUNT, 99, sample value that completes a run.
- MAX_ERRORS, 8, error count that forces the FAIL state; must be >=1.
- STALL_CYCLES, 16, max consecutive cycles in TRACK without in_valid before a stall error.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample qualifier.
- in_count  in  WIDTH  count sample.
- expected  out  WIDTH  next expected value.
- hit_a  out  1  one-cycle pulse, accepted sample == HIT_A.
- hit_b  out  1  one-cycle pulse, accepted sample == HIT_B.
- seen_a  out  1  sticky, HIT_A observed.
- seen_b  out  1  sticky, HIT_B observed.
- err_count  out  16  saturating mismatch+stall error count.
- first_err  out  WIDTH  in_count value of the first mismatch (0 if none).
- done  out  1  run finished (DONE or FAIL state).
- fail  out  1  err_count != 0 or FAIL state.

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; stall counter 0.
  - Reset asserted mid-run clears everything on the next posedge, regardless of state.
- Samples are accepted only when in_valid=1 and state is IDLE or TRACK. All outputs are registered, so effects are visible one cycle after the sampling edge.
- IDLE:
  - in_valid with in_count==0: go to TRACK; expected<=1.
  - in_valid with in_count!=0: mismatch; err_count++; first_err<=in_count if first error; resync expected<=in_count+1; go to TRACK.
- TRACK:
  - in_valid with in_count==expected: expected<=expected+1.
  - in_valid with in_count!=expected: mismatch; err_count++; resync expected<=in_count+1.
  - expected wraps: the all-ones value is followed by expected 0 with no error.
- Completion:
  - An accepted sample equal to END_COUNT moves to DONE, whether or not it was a mismatch. A mismatch is still counted in that same cycle.
- Hits:
  - hit_a/hit_b pulse one cycle after any accepted sample equal to HIT_A/HIT_B, including mismatching samples; seen_* set at the same time.
  - If HIT_A==HIT_B, both fire together.
- Stall:
  - The stall counter runs in TRACK only and clears on in_valid.
  - When it reaches STALL_CYCLES: err_count++ and the counter clears; it may fire repeatedly.
  - Stalls do not update first_err.
- Errors:
  - err_count saturates at 16'hFFFF.
  - When err_count reaches MAX_ERRORS (after this cycle's increment): go to FAIL.
  - A mismatch and a stall in the same cycle cannot occur, because a stall requires in_valid=0.
- DONE/FAIL:
  - Terminal; in_valid is ignored; no hits, no errors, expected frozen.
  - done=1. fail=1 in FAIL, or in DONE when err_count!=0.
  - Leave only via reset.
- Simultaneous END_COUNT sample and MAX_ERRORS reached: FAIL takes priority.

Decomposition:
- Package count_check_pkg holds:
  - the state enum (IDLE, TRACK, DONE, FAIL);
  - ERR_W=16 and the saturating-increment function;
  - default target constants.
- A single sub-module, count_stall_timer, holds the stall counter: inputs enable, clear; output expire pulse.
- Everything else stays in one always_ff block plus next-state logic.

Test Plan:
- Reset, then counts 0..99 with in_valid=1 every cycle:
  - done=1, fail=0, err_count=0 one cycle after sample 99;
  - hit_a pulses once after sample 50; seen_b=0; expected=100.
- Sequence 0..20, skip 21, then 22..99:
  - err_count=1, first_err=22, fail=1, done=1 in DONE (not FAIL).
- First sample 5, then 6..99:
  - err_count=1, first_err=5, expected tracks 6, 7, ...; done=1, fail=1.
- in_valid held low for 40 cycles after sample 10 (STALL_CYCLES=16):
  - err_count=2 after cycles 16 and 32; resuming with 11 adds no mismatch.
- WIDTH=8, END_COUNT=3, stream 254, 255, 0, 1, 2, 3:
  - one error at 254 only, no error across the wrap, done=1.
- 8 consecutive bad samples (MAX_ERRORS=8):
  - FAIL one cycle after the 8th; later samples are ignored.
  - Reset asserted mid-TRACK clears all outputs on the next edge.
